// File: rtl/worker_bus_sequencer.sv
// Sequences a shared worker bus across workers 1..W. A command either
// gathers (reads and sums every worker's rdata) or scatters (writes one
// payload word to every worker). Each access is abandoned after TIMEOUT
// cycles; the worker is flagged in err_mask and skipped.
module worker_bus_sequencer #(
  parameter int W       = 3,
  parameter int IDW     = 3,
  parameter int TIMEOUT = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           op,
  input  logic [31:0]    wdata_in,
  output logic           busy,
  output logic           done,
  output logic [31:0]    sum,
  output logic [W-1:0]   err_mask,
  output logic [IDW-1:0] W_id,
  output logic           W_read,
  input  logic           W_rready,
  input  logic [31:0]    W_rdata,
  output logic           W_write,
  input  logic           W_wready,
  output logic [31:0]    W_wdata
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  state_t         state_q, state_d;
  logic [IDW-1:0] id_q, id_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [31:0]    sum_q, sum_d;
  logic [31:0]    pay_q, pay_d;
  logic [W-1:0]   err_q, err_d;

  logic rdy, tmo;

  // Ready is only honoured for the op in progress; the other strobe's ready is ignored.
  assign rdy = (state_q == RD) ? W_rready : (state_q == WR) ? W_wready : 1'b0;
  assign tmo = (cnt_q == CW'(TIMEOUT - 1));

  // Next-state logic: command acceptance, per-worker advance and timeout.
  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    pay_d   = pay_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          pay_d   = wdata_in;
          sum_d   = '0;
          err_d   = '0;
          id_d    = IDW'(1);
          cnt_d   = '0;
          state_d = op ? WR : RD;
        end
      end
      RD, WR: begin
        if (rdy || tmo) begin
          // Ready on the timeout edge still counts as a successful access.
          if (rdy && state_q == RD) sum_d = sum_q + W_rdata;
          if (!rdy) err_d = err_q | (W'(1) << (id_q - IDW'(1)));
          cnt_d = '0;
          if (id_q == IDW'(W)) begin
            id_d    = '0;
            state_d = DONE;
          end else begin
            id_d = id_q + IDW'(1);
          end
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State register; reset aborts any command without a done pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      pay_q   <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      pay_q   <= pay_d;
      err_q   <= err_d;
    end
  end

  assign busy     = (state_q != IDLE);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign err_mask = err_q;
  assign W_id     = id_q;
  assign W_read   = (state_q == RD);
  assign W_write  = (state_q == WR);
  assign W_wdata  = (state_q == WR) ? pay_q : 32'h0;

endmodule

// File: tb/tb_worker_bus_sequencer.sv
// Bench for worker_bus_sequencer: a programmable worker bank answers the bus,
// each command's expected result is queued when it is issued and compared
// when done pulses.
module tb_worker_bus_sequencer;
  localparam int W = 3, IDW = 3, TIMEOUT = 8;
  localparam int NEVER = 99;

  logic           clk = 1'b0, rst = 1'b1;
  logic           start = 1'b0, op = 1'b0;
  logic [31:0]    wdata_in = '0;
  logic           busy, done;
  logic [31:0]    sum;
  logic [W-1:0]   err_mask;
  logic [IDW-1:0] W_id;
  logic           W_read, W_write, W_rready, W_wready;
  logic [31:0]    W_rdata, W_wdata;

  worker_bus_sequencer #(.W(W), .IDW(IDW), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .wdata_in(wdata_in),
    .busy(busy), .done(done), .sum(sum), .err_mask(err_mask),
    .W_id(W_id), .W_read(W_read), .W_rready(W_rready), .W_rdata(W_rdata),
    .W_write(W_write), .W_wready(W_wready), .W_wdata(W_wdata)
  );

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Worker bank: worker k answers after delay[k] extra cycles of being selected.
  logic [31:0]    wdat  [1:W];
  int             delay [1:W];
  logic [IDW-1:0] last_id = '0;
  int             hreg = 0, hcur;
  logic           rdy_now;

  assign hcur     = (W_id != last_id) ? 0 : hreg + 1;
  assign rdy_now  = (W_id != 0) && (int'(W_id) <= W) && (hcur == delay[int'(W_id)]);
  assign W_rready = W_read && rdy_now;
  assign W_wready = W_write && rdy_now;
  assign W_rdata  = ((W_id != 0) && (int'(W_id) <= W)) ? wdat[int'(W_id)] : 32'hDEADBEEF;

  always @(posedge clk) begin
    last_id <= W_id;
    hreg    <= hcur;
  end

  // Bus monitor: strobe exclusivity, scatter payload, per-worker hold time.
  int          hold [0:W];
  logic [31:0] exp_pay;
  always @(negedge clk) begin
    if (W_read || W_write) check("strobe_excl", {31'b0, W_read & W_write}, 32'd0);
    if (W_write) check("W_wdata", W_wdata, exp_pay);
    if (W_id != 0 && int'(W_id) <= W) hold[int'(W_id)]++;
  end

  typedef struct { logic [31:0] sum; logic [W-1:0] err; int lat; } exp_t;
  exp_t sb[$];

  // Protocol model: a worker is served if it answers within TIMEOUT cycles.
  function automatic exp_t model(input logic o);
    exp_t e;
    e.sum = '0; e.err = '0; e.lat = 1;
    for (int k = 1; k <= W; k++) begin
      if (delay[k] <= TIMEOUT - 1) begin
        e.lat += delay[k] + 1;
        if (!o) e.sum += wdat[k];
      end else begin
        e.lat += TIMEOUT;
        e.err[k-1] = 1'b1;
      end
    end
    return e;
  endfunction

  // Issue a command at a negedge in IDLE and score it at done.
  task automatic run_cmd(input logic o, input logic [31:0] d, input bit spur_busy,
                         input bit spur_done, input int exp_hold2);
    exp_t e;
    int   k;
    bit   seen = 0;
    for (int i = 0; i <= W; i++) hold[i] = 0;
    exp_pay = d;
    start = 1'b1; op = o; wdata_in = d;
    sb.push_back(model(o));
    @(posedge clk);
    for (k = 1; k < 300; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (spur_busy && k == 2) begin
        start = 1'b1; op = ~o; wdata_in = ~d;
      end
      if (done) begin seen = 1; break; end
    end
    if (!seen) begin
      check("done_timeout", 32'd0, 32'd1);
      void'(sb.pop_front());
    end else begin
      e = sb.pop_front();
      check("sum", sum, e.sum);
      check("err_mask", {29'b0, err_mask}, {29'b0, e.err});
      check("latency", k, e.lat);
      check("busy_at_done", {31'b0, busy}, 32'd1);
      if (exp_hold2 >= 0) check("hold_w2", hold[2], exp_hold2);
      if (spur_done) begin start = 1'b1; op = ~o; wdata_in = ~d; end
      @(negedge clk);
      start = 1'b0;
      check("done_single", {31'b0, done}, 32'd0);
      check("idle_after", {31'b0, busy}, 32'd0);
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_busy"}, {31'b0, busy}, 32'd0);
    check({tag, "_done"}, {31'b0, done}, 32'd0);
    check({tag, "_sum"}, sum, 32'd0);
    check({tag, "_err"}, {29'b0, err_mask}, 32'd0);
    check({tag, "_id"}, {29'b0, W_id}, 32'd0);
    check({tag, "_rd"}, {31'b0, W_read}, 32'd0);
    check({tag, "_wr"}, {31'b0, W_write}, 32'd0);
    check({tag, "_wdata"}, W_wdata, 32'd0);
  endtask

  initial begin
    exp_pay = '0;
    for (int k = 1; k <= W; k++) begin wdat[k] = 32'(10 * k); delay[k] = 0; end
    #3 check_zero("reset");
    @(negedge clk); rst = 1'b0;
    @(negedge clk);

    // Fast gather: 10+20+30.
    run_cmd(1'b0, 32'h0, 0, 0, 1);

    // Worker 2 never answers: held TIMEOUT cycles, flagged, skipped.
    wdat[1] = 32'd5; wdat[2] = 32'd1000; wdat[3] = 32'd9; delay[2] = NEVER;
    run_cmd(1'b0, 32'h0, 0, 0, TIMEOUT);

    // Ready exactly on the timeout edge wins.
    delay[2] = TIMEOUT - 1;
    run_cmd(1'b0, 32'h0, 0, 0, TIMEOUT);

    // 32-bit wrap.
    wdat[1] = 32'hFFFFFFFF; wdat[2] = 32'h2; wdat[3] = 32'h0; delay[2] = 0;
    run_cmd(1'b0, 32'h0, 0, 0, 1);

    // Scatter with ready delayed 2 cycles per worker.
    for (int k = 1; k <= W; k++) delay[k] = 2;
    run_cmd(1'b1, 32'hA5A5A5A5, 0, 0, 3);

    // Starts while busy and in the DONE cycle are ignored; next IDLE start accepted.
    for (int k = 1; k <= W; k++) begin wdat[k] = 32'(k + 100); delay[k] = 0; end
    run_cmd(1'b0, 32'h0, 1, 1, 1);
    run_cmd(1'b1, 32'h12345678, 0, 0, 1);

    // Reset mid-gather at worker 2 aborts without done.
    delay[2] = NEVER;
    start = 1'b1; op = 1'b0;
    @(posedge clk);
    begin
      bit at2 = 0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clk); start = 1'b0;
        if (W_id == 3'd2) begin at2 = 1; break; end
      end
      check("reach_w2", {31'b0, at2}, 32'd1);
    end
    @(negedge clk);
    #2 rst = 1'b1;
    #1 check_zero("midrst");
    @(negedge clk);
    check("midrst_nodone", {31'b0, done}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    delay[2] = 0;
    run_cmd(1'b0, 32'h0, 0, 0, 1);

    check("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
